led_blink_sched: RTL

//  Round-robin scheduler that shares the single board LED among N_REQ requesters.

---
 rtl/led_blink_sched.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/led_blink_sched.sv
// Round-robin scheduler sharing one LED among N_REQ requesters: grant, blink burst, gap, ack.
// Optional macro LED_DIM_EN: PWM-dims the ON phase with an 8-bit free-running counter.
module led_blink_sched #(
    parameter int N_REQ    = 4,
    parameter int CLK_HZ   = 25_000_000,
    parameter int HALF_0   = CLK_HZ / 200,
    parameter int HALF_1   = CLK_HZ / 100,
    parameter int HALF_2   = CLK_HZ / 20,
    parameter int HALF_3   = CLK_HZ / 2,
    parameter int GAP_CYC  = CLK_HZ / 4,
    parameter int DIM_DUTY = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     i_req,
    input  logic [2*N_REQ-1:0]   i_rate,
    input  logic [4*N_REQ-1:0]   i_count,
    output logic [N_REQ-1:0]     o_ack,
    output logic                 o_busy,
    output logic [2:0]           o_grant_id,
    output logic                 LED
);
    localparam int MAX_01  = (HALF_0 > HALF_1) ? HALF_0 : HALF_1;
    localparam int MAX_23  = (HALF_2 > HALF_3) ? HALF_2 : HALF_3;
    localparam int MAX_H   = (MAX_01 > MAX_23) ? MAX_01 : MAX_23;
    localparam int MAX_ALL = (MAX_H > GAP_CYC) ? MAX_H : GAP_CYC;
    localparam int PH_W    = ($clog2(MAX_ALL) > 0) ? $clog2(MAX_ALL) : 1;

    // Phase counter holds "cycles remaining minus one", so it only needs to reach duration-1.
    localparam logic [PH_W-1:0] H0_M1  = PH_W'(HALF_0 - 1);
    localparam logic [PH_W-1:0] H1_M1  = PH_W'(HALF_1 - 1);
    localparam logic [PH_W-1:0] H2_M1  = PH_W'(HALF_2 - 1);
    localparam logic [PH_W-1:0] H3_M1  = PH_W'(HALF_3 - 1);
    localparam logic [PH_W-1:0] GAP_M1 = PH_W'(GAP_CYC - 1);
    localparam logic [PH_W-1:0] PH_ONE = PH_W'(1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ON   = 3'd1,
        S_OFF  = 3'd2,
        S_GAP  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t           state_reg,   state_next;
    logic [PH_W-1:0]  phase_reg,   phase_next;
    logic [1:0]       rate_reg,    rate_next;
    logic [3:0]       count_reg,   count_next;
    logic [2:0]       grant_reg,   grant_next;
    logic [2:0]       rr_ptr_reg,  rr_ptr_next;
    logic             aborted_reg, aborted_next;
    logic             led_reg,     led_next;
    logic [N_REQ-1:0] ack_reg,     ack_next;

    logic             led_on_level;
    logic [7:0]       req_ext;
    logic [1:0]       rate_arr  [8];
    logic [3:0]       count_arr [8];

    // Pad per-requester fields to 8 slots so a 3-bit index is always in range.
    assign req_ext = 8'(i_req);

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_fields
            if (gi < N_REQ) begin : g_used
                assign rate_arr[gi]  = i_rate[2*gi +: 2];
                assign count_arr[gi] = i_count[4*gi +: 4];
            end else begin : g_pad
                assign rate_arr[gi]  = 2'd0;
                assign count_arr[gi] = 4'd0;
            end
        end
    endgenerate

    function automatic logic [PH_W-1:0] half_m1(input logic [1:0] rate);
        case (rate)
            2'd0:    half_m1 = H0_M1;
            2'd1:    half_m1 = H1_M1;
            2'd2:    half_m1 = H2_M1;
            default: half_m1 = H3_M1;
        endcase
    endfunction

    // Round-robin pick: first set request at or above rr_ptr, wrapping.
    logic       req_found;
    logic [2:0] req_pick;
    logic [2:0] scan_idx;

    always_comb begin
        req_found = 1'b0;
        req_pick  = 3'd0;
        scan_idx  = 3'd0;
        for (int i = 0; i < N_REQ; i++) begin
            scan_idx = 3'((int'(rr_ptr_reg) + i) % N_REQ);
            if (!req_found && req_ext[scan_idx]) begin
                req_found = 1'b1;
                req_pick  = scan_idx;
            end
        end
    end

    always_comb begin
        state_next   = state_reg;
        phase_next   = phase_reg;
        rate_next    = rate_reg;
        count_next   = count_reg;
        grant_next   = grant_reg;
        rr_ptr_next  = rr_ptr_reg;
        aborted_next = aborted_reg;
        case (state_reg)
            S_IDLE: begin
                if (req_found) begin
                    grant_next   = req_pick;
                    rate_next    = rate_arr[req_pick];
                    count_next   = count_arr[req_pick];
                    aborted_next = 1'b0;
                    if (count_arr[req_pick] != 4'd0) begin
                        state_next = S_ON;
                        phase_next = half_m1(rate_arr[req_pick]);
                    end else begin
                        state_next = S_GAP;
                        phase_next = GAP_M1;
                    end
                end
            end
            S_ON: begin
                if (!req_ext[grant_reg]) begin
                    state_next   = S_GAP;
                    phase_next   = GAP_M1;
                    aborted_next = 1'b1;
                end else if (phase_reg == '0) begin
                    state_next = S_OFF;
                    phase_next = half_m1(rate_reg);
                end else begin
                    phase_next = phase_reg - PH_ONE;
                end
            end
            S_OFF: begin
                if (!req_ext[grant_reg]) begin
                    state_next   = S_GAP;
                    phase_next   = GAP_M1;
                    aborted_next = 1'b1;
                end else if (phase_reg == '0) begin
                    count_next = count_reg - 4'd1;
                    if (count_reg == 4'd1) begin
                        state_next = S_GAP;
                        phase_next = GAP_M1;
                    end else begin
                        state_next = S_ON;
                        phase_next = half_m1(rate_reg);
                    end
                end else begin
                    phase_next = phase_reg - PH_ONE;
                end
            end
            S_GAP: begin
                if (phase_reg == '0) begin
                    state_next = S_DONE;
                end else begin
                    phase_next = phase_reg - PH_ONE;
                end
            end
            S_DONE: begin
                rr_ptr_next = 3'((int'(grant_reg) + 1) % N_REQ);
                state_next  = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
        // Outputs are registered from the next state so they line up with the state register.
        led_next = (state_next == S_ON) && led_on_level;
        ack_next = (state_next == S_DONE && !aborted_reg) ? N_REQ'(8'd1 << grant_reg) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= S_IDLE;
            phase_reg   <= '0;
            rate_reg    <= 2'd0;
            count_reg   <= 4'd0;
            grant_reg   <= 3'd0;
            rr_ptr_reg  <= 3'd0;
            aborted_reg <= 1'b0;
            led_reg     <= 1'b0;
            ack_reg     <= '0;
        end else begin
            state_reg   <= state_next;
            phase_reg   <= phase_next;
            rate_reg    <= rate_next;
            count_reg   <= count_next;
            grant_reg   <= grant_next;
            rr_ptr_reg  <= rr_ptr_next;
            aborted_reg <= aborted_next;
            led_reg     <= led_next;
            ack_reg     <= ack_next;
        end
    end

`ifdef LED_DIM_EN
    logic [7:0] pwm_cnt_reg;
    logic       clk_hz_unused;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt_reg <= 8'd0;
        end else begin
            pwm_cnt_reg <= pwm_cnt_reg + 8'd1;
        end
    end

    assign led_on_level  = (int'(pwm_cnt_reg) < DIM_DUTY);
    assign clk_hz_unused = (CLK_HZ != 0);
`else
    logic cfg_unused;

    assign led_on_level = 1'b1;
    assign cfg_unused   = (CLK_HZ != 0) ^ (DIM_DUTY != 0);
`endif

    assign o_ack      = ack_reg;
    assign o_busy     = (state_reg != S_IDLE);
    assign o_grant_id = grant_reg;
    assign LED        = led_reg;

endmodule
